serial_magnitude_comparator: RTL
================================

// Module: serial_magnitude_comparator
// PURPOSE
//  Parametrised successor to the fixed 4-bit lt/eq/gt comparator.
//  Compares two WIDTH-bit operands CHUNK bits per clock, MSB-first, and terminates early on the first differing chunk.
//  Supports both unsigned and two's-complement signed compare.
//  Uses a valid/ready handshake on input and output; sits between operand registers and the datapath control FSM.
// PARAMETERS
//  WIDTH   16  operand width in bits; must be an integer multiple of CHUNK
//  CHUNK   4   bits compared per cycle (1..WIDTH)
//  NCHUNK  WIDTH/CHUNK  localparam: number of chunks; CW = clog2(NCHUNK+1) is the count width
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       operands/mode valid
//  in_ready     out  1       block can accept operands
//  a            in   WIDTH   operand A
//  b            in   WIDTH   operand B
//  signed_mode  in   1       1 = two's-complement compare, 0 = unsigned
//  out_valid    out  1       result valid
//  out_ready    in   1       consumer accepts result
//  a_lt_b       out  1       A < B (registered)
//  a_eq_b       out  1       A == B (registered)
//  a_gt_b       out  1       A > B (registered)
//  chunks_used  out  CW      number of chunks examined, 1..NCHUNK
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; lt/eq/gt=0; chunks_used=0; idx=NCHUNK-1.
//  States:
//   IDLE  in_ready=1. On in_valid: capture a, b, signed_mode; idx<=NCHUNK-1; go to CMP.
//   CMP   in_ready=0. Compare chunk idx of the captured operands.
//         - Chunk differs: register lt/gt (eq=0), chunks_used=NCHUNK-idx, go to DONE.
//         - Chunk equal and idx==0: register eq=1, chunks_used=NCHUNK, go to DONE.
//         - Otherwise: idx<=idx-1, stay in CMP.
//   DONE  out_valid=1; outputs held stable. On out_ready: out_valid<=0, go to IDLE.
//  Signed mode: invert the MSB of both captured operands (offset-binary), then compare unsigned.
//  Latency: out_valid rises exactly chunks_used+1 edges after the accepting edge.
//  Throughput: one compare per transaction; no overlap. in_ready=0 from CMP until DONE is left.
//  Exactly one of lt/eq/gt is 1 whenever out_valid=1. All three are 0 only after reset, before the first result.
//  Inputs a/b/signed_mode may change freely after capture; the result is unaffected.
//  CHUNK==WIDTH: degenerates to a single-cycle compare; chunks_used is always 1.
//  Async reset asserted in any state aborts the transaction; any partial result is discarded.
//  out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored.
// CONFIGURATION
//  MINMAX_OUT_EN defined: adds ports min_out, max_out (out, WIDTH each).
//   - Registered together with the result; min=max=A when equal; interpreted per captured signed_mode.
//   - Reset value 0.
//  MINMAX_OUT_EN undefined: ports absent; no extra registers.
// STRUCTURE
//  Shared header cmp_defs.vh:
//   - state encodings ST_IDLE=2'd0, ST_CMP=2'd1, ST_DONE=2'd2.
//   - clog2 function used for CW.
//  Sub-module chunk_compare #(CHUNK): combinational lt/eq/gt of one CHUNK-bit slice, instantiated once.
//  Top level holds the FSM, operand registers, idx down-counter, and result registers.
// TESTING (WIDTH=16, CHUNK=4)
//  1. a=16'h1234, b=16'h1234, unsigned -> eq=1, chunks_used=4, out_valid 5 edges after accept.
//  2. a=16'h8000, b=16'h7FFF, unsigned -> gt=1, chunks_used=1; same operands signed -> lt=1, chunks_used=1.
//  3. a=16'h1235, b=16'h1234 -> gt=1, chunks_used=4; a=16'h1034, b=16'h1234 -> lt=1, chunks_used=2.
//  4. Result ready, out_ready held low 6 cycles -> out_valid and lt/eq/gt stable; in_ready=0; in_valid pulses ignored.
//  5. rst_n low during CMP of case 1 -> next cycle in_ready=1, out_valid=0; a fresh a=3, b=5 gives lt=1.
//  6. MINMAX_OUT_EN, signed, a=16'hFFFE (-2), b=16'h0003 -> min_out=16'hFFFE, max_out=16'h0003, lt=1.

Source files
------------

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared FSM state encodings and the width helper used to size the chunk counters.
package serial_magnitude_comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to hold values 0..v-1 (0 for v<=1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational lt/eq/gt of one CHUNK-bit unsigned slice.
module chunk_compare #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first chunked magnitude comparator with early exit and valid/ready on both sides.
// Optional MINMAX_OUT_EN adds registered min_out/max_out ports.
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic [CW-1:0]    chunks_used
`ifdef MINMAX_OUT_EN
  ,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out
`endif
);

  localparam int IW = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  state_t state, state_nxt;
  logic [NCHUNK-1:0][CHUNK-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             decide;
  logic             c_lt, c_eq, c_gt;
  logic [WIDTH-1:0] msb_flip;

  // Offset-binary: flipping both MSBs turns a signed compare into an unsigned one.
  assign msb_flip = WIDTH'(signed_mode) << (WIDTH - 1);

  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .a  (a_q[idx]),
    .b  (b_q[idx]),
    .lt (c_lt),
    .eq (c_eq),
    .gt (c_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    decide    = 1'b0;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_CMP;
      ST_CMP: begin
        if (!c_eq || idx == '0) begin
          state_nxt = ST_DONE;
          decide    = 1'b1;
        end
      end
      ST_DONE: if (out_valid && out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready = (state == ST_IDLE);

`ifdef MINMAX_OUT_EN
  logic             sm_q;
  logic [WIDTH-1:0] a_orig, b_orig;
  assign a_orig = a_q ^ (WIDTH'(sm_q) << (WIDTH - 1));
  assign b_orig = b_q ^ (WIDTH'(sm_q) << (WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      idx         <= IW'(NCHUNK - 1);
      a_lt_b      <= 1'b0;
      a_eq_b      <= 1'b0;
      a_gt_b      <= 1'b0;
      chunks_used <= '0;
      out_valid   <= 1'b0;
`ifdef MINMAX_OUT_EN
      sm_q        <= 1'b0;
      min_out     <= '0;
      max_out     <= '0;
`endif
    end else begin
      if (state == ST_IDLE && in_valid) begin
        a_q <= a ^ msb_flip;
        b_q <= b ^ msb_flip;
        idx <= IW'(NCHUNK - 1);
`ifdef MINMAX_OUT_EN
        sm_q <= signed_mode;
`endif
      end
      if (state == ST_CMP) begin
        if (decide) begin
          a_lt_b      <= c_lt;
          a_eq_b      <= c_eq;
          a_gt_b      <= c_gt;
          chunks_used <= CW'(NCHUNK) - CW'(idx);
`ifdef MINMAX_OUT_EN
          min_out     <= c_gt ? b_orig : a_orig;
          max_out     <= c_gt ? a_orig : b_orig;
`endif
        end else begin
          idx <= idx - IW'(1);
        end
      end
      // Advertise one edge after the result flops load, so out_valid never precedes its data.
      if (state == ST_DONE && !out_valid) out_valid <= 1'b1;
      else if (out_valid && out_ready)    out_valid <= 1'b0;
    end
  end

endmodule
